// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined RISC-V immediate generator:
// major-opcode values (inst[6:2]), shift funct3 codes and the format-code enum.
package imm_gen_pkg;

   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_ZIMM  = 3'd7
   } fmt_e;

   function automatic logic is_shift_f3(input logic [2:0] f3);
      return (f3 == F3_SLLI) || (f3 == F3_SRXI);
   endfunction

endpackage

// File: rtl/imm_gen_dec.sv
// Combinational immediate decoder: instruction word -> XLEN immediate, format, illegal flag.
// Optional macro IMM_GEN_ZIMM_EN enables ZIMM decode of CSR*I instructions.
module imm_gen_dec
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_e            fmt_o,
   output logic            illegal_o
);

   logic shift_s;

   assign shift_s = is_shift_f3(inst_i[14:12]);

   // Format select and immediate assembly; everything not listed is illegal.
   always_comb begin
      imm_o     = {XLEN{1'b0}};
      fmt_o     = FMT_NONE;
      illegal_o = 1'b0;
      if (inst_i[1:0] != 2'b11) begin
         illegal_o = 1'b1;
      end else begin
         case (inst_i[6:2])
            OPC_LUI, OPC_AUIPC: begin
               imm_o = XLEN'($signed({inst_i[31:12], 12'h000}));
               fmt_o = FMT_U;
            end
            OPC_JAL: begin
               imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
               fmt_o = FMT_J;
            end
            OPC_JALR, OPC_LOAD: begin
               imm_o = XLEN'($signed(inst_i[31:20]));
               fmt_o = FMT_I;
            end
            OPC_BRANCH: begin
               imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
               fmt_o = FMT_B;
            end
            OPC_STORE: begin
               imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
               fmt_o = FMT_S;
            end
            OPC_OP_IMM: begin
               if (shift_s) begin
                  imm_o = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
                  fmt_o = FMT_SHAMT;
               end else begin
                  imm_o = XLEN'($signed(inst_i[31:20]));
                  fmt_o = FMT_I;
               end
            end
            OPC_OP_IMM_32: begin
               // W-form ops only exist on RV64; their shift amount is always 5 bits.
               if (XLEN != 64) begin
                  illegal_o = 1'b1;
               end else if (shift_s) begin
                  imm_o = XLEN'(inst_i[24:20]);
                  fmt_o = FMT_SHAMT;
               end else begin
                  imm_o = XLEN'($signed(inst_i[31:20]));
                  fmt_o = FMT_I;
               end
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
               if (inst_i[14]) begin
                  imm_o = XLEN'(inst_i[19:15]);
                  fmt_o = FMT_ZIMM;
               end else begin
                  fmt_o = FMT_NONE;
               end
`else
               fmt_o = FMT_NONE;
`endif
            end
            default: begin
               illegal_o = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder + one output register + one skid entry,
// valid/ready on both sides, in_ready registered. Optional macro: IMM_GEN_ZIMM_EN.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  dec_imm_s;
   fmt_e             dec_fmt_s;
   logic             dec_ill_s;

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   fmt_e             out_fmt_q,   out_fmt_d;
   logic             out_ill_q,   out_ill_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   fmt_e             skid_fmt_q,   skid_fmt_d;
   logic             skid_ill_q,   skid_ill_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

   logic             accept_s;
   logic             out_free_s;

   imm_gen_dec #(.XLEN(XLEN)) u_dec (
      .inst_i    (in_inst),
      .imm_o     (dec_imm_s),
      .fmt_o     (dec_fmt_s),
      .illegal_o (dec_ill_s)
   );

   assign accept_s   = in_valid & ~skid_valid_q;
   assign out_free_s = ~out_valid_q | out_ready;

   // Output/skid steering; a pending skid entry always goes out before new input.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_fmt_d    = out_fmt_q;
      out_ill_d    = out_ill_q;
      out_tag_d    = out_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;
      skid_ill_d   = skid_ill_q;
      skid_tag_d   = skid_tag_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free_s) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_fmt_d    = skid_fmt_q;
            out_ill_d    = skid_ill_q;
            out_tag_d    = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm_s;
            out_fmt_d   = dec_fmt_s;
            out_ill_d   = dec_ill_s;
            out_tag_d   = in_tag;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept_s) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm_s;
         skid_fmt_d   = dec_fmt_s;
         skid_ill_d   = dec_ill_s;
         skid_tag_d   = in_tag;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= {XLEN{1'b0}};
         out_fmt_q    <= FMT_NONE;
         out_ill_q    <= 1'b0;
         out_tag_q    <= {TAG_W{1'b0}};
         skid_valid_q <= 1'b0;
         skid_imm_q   <= {XLEN{1'b0}};
         skid_fmt_q   <= FMT_NONE;
         skid_ill_q   <= 1'b0;
         skid_tag_q   <= {TAG_W{1'b0}};
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_fmt_q    <= out_fmt_d;
         out_ill_q    <= out_ill_d;
         out_tag_q    <= out_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_fmt_q   <= skid_fmt_d;
         skid_ill_q   <= skid_ill_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

   assign in_ready    = ~skid_valid_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_imm_q;
   assign out_fmt     = out_fmt_q;
   assign out_illegal = out_ill_q;
   assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: identical stimulus into an XLEN=32 and an XLEN=64 instance.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst = 32'h0;
   logic [7:0]  in_tag = 8'h0;

   logic        rdy32, ov32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [7:0]  tag32;
   logic        rdy64, ov64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [7:0]  tag64;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [7:0]  tag;
   } sb_t;

   typedef struct packed {
      logic [31:0] inst;
      exp_t        e32;
      exp_t        e64;
   } vec_t;

   sb_t  q32[$];
   sb_t  q64[$];
   vec_t vq[$];

   int n_tests = 0;
   int n_fail  = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor, XLEN=32 instance: compare every transfer against the scoreboard.
   always @(negedge clk) begin : mon32
      sb_t e;
      if (!rst && !flush && ov32 && out_ready) begin
         if (q32.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL x32_spurious: got output tag %0d expected no output", tag32);
         end else begin
            e = q32.pop_front();
            check("x32_imm", {32'h0, imm32}, {32'h0, e.imm[31:0]});
            check("x32_fmt", {61'h0, fmt32}, {61'h0, e.fmt});
            check("x32_ill", {63'h0, ill32}, {63'h0, e.ill});
            check("x32_tag", {56'h0, tag32}, {56'h0, e.tag});
         end
      end
   end

   // Monitor, XLEN=64 instance.
   always @(negedge clk) begin : mon64
      sb_t e;
      if (!rst && !flush && ov64 && out_ready) begin
         if (q64.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL x64_spurious: got output tag %0d expected no output", tag64);
         end else begin
            e = q64.pop_front();
            check("x64_imm", imm64, e.imm);
            check("x64_fmt", {61'h0, fmt64}, {61'h0, e.fmt});
            check("x64_ill", {63'h0, ill64}, {63'h0, e.ill});
            check("x64_tag", {56'h0, tag64}, {56'h0, e.tag});
         end
      end
   end

   // Outputs must not move while stalled.
   logic        stall_prev = 1'b0;
   logic [44:0] snap = 45'h0;
   always @(negedge clk) begin
      if (rst || flush) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev)
            check("x32_stall_hold", {19'h0, ov32, tag32, fmt32, ill32, imm32}, {19'h0, snap});
         stall_prev <= ov32 && !out_ready;
         snap       <= {1'b1, tag32, fmt32, ill32, imm32};
      end
   end

   task automatic send(input logic [31:0] inst, input logic [7:0] tag,
                       input exp_t e32, input exp_t e64, input bit push);
      int waited = 0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_tag   = tag;
      while (!(rdy32 && rdy64) && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!(rdy32 && rdy64)) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: tag %0d in_ready %b expected 1", tag, rdy32);
      end else if (push) begin
         q32.push_back('{imm: e32.imm, fmt: e32.fmt, ill: e32.ill, tag: tag});
         q64.push_back('{imm: e64.imm, fmt: e64.fmt, ill: e64.ill, tag: tag});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int w = 0;
      out_ready = 1'b1;
      while ((q32.size() != 0 || q64.size() != 0) && w < 30) begin
         @(posedge clk); #1;
         w++;
      end
      check({name, "_q32_left"}, 64'(q32.size()), 64'd0);
      check({name, "_q64_left"}, 64'(q64.size()), 64'd0);
   endtask

   task automatic add(input logic [31:0] inst, input logic [31:0] i32, input logic [2:0] f32,
                      input logic l32, input logic [63:0] i64, input logic [2:0] f64, input logic l64);
      vq.push_back('{inst: inst, e32: '{imm: {32'h0, i32}, fmt: f32, ill: l32},
                                 e64: '{imm: i64, fmt: f64, ill: l64}});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      vec_t v;
      // fmt codes: 0 NONE 1 I 2 S 3 B 4 U 5 J 6 SHAMT 7 ZIMM
      add(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0); // ADDI -1
      add(32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0); // SW -4
      add(32'h123452B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0); // LUI
      add(32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0); // JAL -8
      add(32'h02109093, 32'h00000001, 3'd6, 1'b0, 64'h0000000000000021, 3'd6, 1'b0); // SLLI 33
      add(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0); // BEQ -4
      add(32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0); // JALR -4
      add(32'h80000017, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0); // AUIPC
      add(32'h80004083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0); // LBU -2048
      add(32'h0050809B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000005, 3'd1, 1'b0); // ADDIW 5
      add(32'h0010909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd6, 1'b0); // SLLIW 1
      add(32'h00000010, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1); // low pair 00
      add(32'h00000033, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1); // OP: unsupported
`ifdef IMM_GEN_ZIMM_EN
      add(32'h300FD073, 32'h0000001F, 3'd7, 1'b0, 64'h000000000000001F, 3'd7, 1'b0); // CSRRWI 31
      add(32'h30001073, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0); // CSRRW
`else
      add(32'h300FD073, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0); // CSRRWI
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {63'h0, ov32}, 64'd0);
      check("rst_in_ready",  {63'h0, rdy32}, 64'd1);
      check("rst_out_imm",   imm64, 64'd0);
      check("rst_out_fmt",   {61'h0, fmt32}, 64'd0);
      check("rst_out_ill",   {63'h0, ill32}, 64'd0);
      check("rst_out_tag",   {56'h0, tag64}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back decode at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         send(v.inst, 8'(i + 1), v.e32, v.e64, 1'b1);
      end
      drain("stream");

      // Backpressure: tag 1 in output, tag 2 in skid, tag 3 held off
      out_ready = 1'b0;
      send(vq[0].inst, 8'd1, vq[0].e32, vq[0].e64, 1'b1);
      send(vq[1].inst, 8'd2, vq[1].e32, vq[1].e64, 1'b1);
      check("bp_in_ready_low", {63'h0, rdy32}, 64'd0);
      in_valid = 1'b1;
      in_inst  = vq[2].inst;
      in_tag   = 8'd3;
      repeat (3) begin
         @(posedge clk); #1;
         check("bp_hold_in_ready", {63'h0, rdy64}, 64'd0);
         check("bp_out_tag", {56'h0, tag32}, 64'd1);
      end
      out_ready = 1'b1;
      send(vq[2].inst, 8'd3, vq[2].e32, vq[2].e64, 1'b1);
      drain("bp");

      // Flush with output and skid both full and a same-cycle input
      out_ready = 1'b0;
      send(vq[3].inst, 8'd10, vq[3].e32, vq[3].e64, 1'b0);
      send(vq[4].inst, 8'd11, vq[4].e32, vq[4].e64, 1'b0);
      in_valid = 1'b1;
      in_inst  = vq[5].inst;
      in_tag   = 8'd12;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid32", {63'h0, ov32}, 64'd0);
      check("flush_out_valid64", {63'h0, ov64}, 64'd0);
      check("flush_in_ready",    {63'h0, rdy32}, 64'd1);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("flush_no_emit", {63'h0, ov32 | ov64}, 64'd0);

      // Asynchronous reset with an entry in flight
      out_ready = 1'b0;
      send(vq[0].inst, 8'd20, vq[0].e32, vq[0].e64, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", {63'h0, ov32}, 64'd0);
      check("midrst_out_imm",   {32'h0, imm32}, 64'd0);
      check("midrst_out_tag",   {56'h0, tag32}, 64'd0);
      check("midrst_in_ready",  {63'h0, rdy64}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Recovery after reset
      out_ready = 1'b1;
      send(vq[2].inst, 8'd30, vq[2].e32, vq[2].e64, 1'b1);
      drain("recover");
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
